// File: rtl/data_mem.sv
// Data memory and MMIO window downstream of the MEM stage: word RAM with byte/half/word
// access, byte TX FIFO, STATUS flags; optional cycle counter under DMEM_CYCLE_CTR_EN.
module data_mem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_mem_addr,
  input  logic [3:0]  MEM_mem_cmd,
  input  logic [31:0] MEM_mem_din,
  output logic [31:0] DM_mem_dout,
  output logic        DM_misaligned,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [3:0] CMD_LB  = 4'd1;
  localparam logic [3:0] CMD_LH  = 4'd2;
  localparam logic [3:0] CMD_LW  = 4'd3;
  localparam logic [3:0] CMD_LBU = 4'd4;
  localparam logic [3:0] CMD_LHU = 4'd5;
  localparam logic [3:0] CMD_SB  = 4'd6;
  localparam logic [3:0] CMD_SH  = 4'd7;
  localparam logic [3:0] CMD_SW  = 4'd8;

  logic [3:0]    cmd;
  logic          is_load, half_cmd, word_cmd, misal, mis_set;
  logic          ram_hit, mmio_hit, ram_acc, mmio_acc;
  logic [1:0]    mmio_reg;
  logic [AW-1:0] widx;

  assign cmd      = MEM_mem_cmd;
  assign is_load  = (cmd >= CMD_LB) && (cmd <= CMD_LHU);
  assign half_cmd = (cmd == CMD_LH) || (cmd == CMD_LHU) || (cmd == CMD_SH);
  assign word_cmd = (cmd == CMD_LW) || (cmd == CMD_SW);
  assign misal    = (half_cmd && MEM_mem_addr[0]) || (word_cmd && (MEM_mem_addr[1:0] != 2'b00));
  assign ram_hit  = (MEM_mem_addr >> (AW + 2)) == 32'd0;
  assign mmio_hit = MEM_mem_addr[31:4] == MMIO_BASE[31:4];
  assign mmio_reg = MEM_mem_addr[3:2];
  assign widx     = MEM_mem_addr[AW+1:2];
  assign ram_acc  = ram_hit && !mmio_hit && !misal;
  assign mmio_acc = mmio_hit && !misal;
  // Only word accesses are meaningful in the MMIO window, so only they can flag misalignment there.
  assign mis_set  = misal && (!mmio_hit || word_cmd);

  // RAM: asynchronous read, byte-enabled synchronous write, no reset.
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rword, wdata;
  logic [3:0]  be;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rword = mem[widx];
  assign rbyte = rword[{MEM_mem_addr[1:0], 3'b000} +: 8];
  assign rhalf = rword[{MEM_mem_addr[1], 4'b0000} +: 16];

  always_comb begin
    be    = 4'b0000;
    wdata = MEM_mem_din;
    if (ram_acc) begin
      case (cmd)
        CMD_SB: begin
          be    = 4'b0001 << MEM_mem_addr[1:0];
          wdata = {4{MEM_mem_din[7:0]}};
        end
        CMD_SH: begin
          be    = MEM_mem_addr[1] ? 4'b1100 : 4'b0011;
          wdata = {2{MEM_mem_din[15:0]}};
        end
        CMD_SW:  be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // TX FIFO. Handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
  // tx_data holds steady while tx_valid=1 and tx_ready=0, and tx_valid never drops without a transfer.
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          overflow, full, pop, push_req, push, ovf_set, stat_wr;
  logic [31:0]   status, cyc_rd;

  assign full     = (count == FULL_CNT);
  assign tx_valid = (count != '0);
  assign tx_data  = fifo_mem[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  assign push_req = mmio_acc && (cmd == CMD_SW) && (mmio_reg == 2'd0);
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign stat_wr  = mmio_acc && (cmd == CMD_SW) && (mmio_reg == 2'd1);
  assign status   = {24'b0, 4'(count), DM_misaligned, overflow, full, !tx_valid};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      DM_misaligned <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 8'h00;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= MEM_mem_din[7:0];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // A new set beats a same-cycle clear.
      if (ovf_set)                         overflow <= 1'b1;
      else if (stat_wr && MEM_mem_din[2])  overflow <= 1'b0;
      if (mis_set)                         DM_misaligned <= 1'b1;
      else if (stat_wr && MEM_mem_din[3])  DM_misaligned <= 1'b0;
    end
  end

`ifdef DMEM_CYCLE_CTR_EN
  logic [31:0] cyc_q;
  logic        cyc_wr;
  assign cyc_wr = mmio_acc && (cmd == CMD_SW) && (mmio_reg == 2'd2);
  assign cyc_rd = cyc_q;

  // A write lands one count ahead so the next cycle already reads din+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cyc_q <= 32'd0;
    else if (cyc_wr) cyc_q <= MEM_mem_din + 32'd1;
    else             cyc_q <= cyc_q + 32'd1;
  end
`else
  assign cyc_rd = 32'd0;
`endif

  always_comb begin
    DM_mem_dout = 32'd0;
    if (is_load && !misal) begin
      if (mmio_hit) begin
        if (cmd == CMD_LW) begin
          case (mmio_reg)
            2'd1:    DM_mem_dout = status;
            2'd2:    DM_mem_dout = cyc_rd;
            default: DM_mem_dout = 32'd0;
          endcase
        end
      end else if (ram_hit) begin
        case (cmd)
          CMD_LB:  DM_mem_dout = {{24{rbyte[7]}}, rbyte};
          CMD_LBU: DM_mem_dout = {24'b0, rbyte};
          CMD_LH:  DM_mem_dout = {{16{rhalf[15]}}, rhalf};
          CMD_LHU: DM_mem_dout = {16'b0, rhalf};
          CMD_LW:  DM_mem_dout = rword;
          default: DM_mem_dout = 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed scenarios plus random traffic against a byte-array/queue model.
// Honours DMEM_CYCLE_CTR_EN the same way as the design.
module tb_data_mem;

  localparam int          DEPTH_WORDS = 1024;
  localparam int          FD          = 8;
  localparam logic [31:0] BASE        = 32'hFFFF_0000;

  localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                         LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, din;
  logic [3:0]  cmd;
  logic        tx_ready;
  logic [31:0] dout;
  logic        mis;
  logic [7:0]  tx_data;
  logic        tx_valid;

  data_mem #(.DEPTH_WORDS(DEPTH_WORDS), .FIFO_DEPTH(FD), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .MEM_mem_addr(addr), .MEM_mem_cmd(cmd), .MEM_mem_din(din),
    .DM_mem_dout(dout), .DM_misaligned(mis),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [7:0]    m_mem [DEPTH_WORDS*4];
  bit [7:0]    mq [$];
  bit          m_mis, m_ovf;
  bit [31:0]   m_cyc;

  int          n_checks, n_errors;
  logic [31:0] seen_dout;
  logic [7:0]  seen_txd;
  logic        seen_txv, seen_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_is_mmio(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic bit m_is_ram(input logic [31:0] a);
    return a < 32'(DEPTH_WORDS * 4);
  endfunction

  function automatic bit m_misal(input logic [3:0] c, input logic [31:0] a);
    if (c == LH || c == LHU || c == SH) return a % 2 != 0;
    if (c == LW || c == SW)             return a % 4 != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_status();
    return {24'b0, 4'(mq.size()), m_mis, m_ovf, mq.size() == FD, mq.size() == 0};
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] c, input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    if (!(c inside {LB, LH, LW, LBU, LHU}) || m_misal(c, a)) return 32'd0;
    if (m_is_mmio(a)) begin
      if (c != LW) return 32'd0;
      if (a[3:0] == 4'h4) return m_status();
`ifdef DMEM_CYCLE_CTR_EN
      if (a[3:0] == 4'h8) return m_cyc;
`endif
      return 32'd0;
    end
    if (!m_is_ram(a)) return 32'd0;
    b = m_mem[a];
    h = {m_mem[a+1], m_mem[a]};
    case (c)
      LB:      return {{24{b[7]}}, b};
      LBU:     return {24'b0, b};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'b0, h};
      default: return {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
    endcase
  endfunction

  task automatic m_step(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    bit pop, bad, mm, ovf_set, mis_set;
    int sz;
    sz      = mq.size();
    pop     = (sz > 0) && rdy;
    bad     = m_misal(c, a);
    mm      = m_is_mmio(a);
    mis_set = bad && (!mm || c == LW || c == SW);
    ovf_set = 1'b0;
    if (pop) void'(mq.pop_front());
    if (mm && !bad && c == SW) begin
      if (a[3:0] == 4'h0) begin
        if (sz < FD || pop) mq.push_back(d[7:0]);
        else ovf_set = 1'b1;
      end
      if (a[3:0] == 4'h4) begin
        if (d[2]) m_ovf = 1'b0;
        if (d[3]) m_mis = 1'b0;
      end
    end
    if (ovf_set) m_ovf = 1'b1;
    if (mis_set) m_mis = 1'b1;
`ifdef DMEM_CYCLE_CTR_EN
    if (mm && !bad && c == SW && a[3:0] == 4'h8) m_cyc = d + 32'd1;
    else m_cyc = m_cyc + 32'd1;
`endif
    if (!mm && m_is_ram(a) && !bad) begin
      case (c)
        SB: m_mem[a] = d[7:0];
        SH: begin m_mem[a] = d[7:0]; m_mem[a+1] = d[15:8]; end
        SW: for (int k = 0; k < 4; k++) m_mem[a+k] = d[8*k +: 8];
        default: ;
      endcase
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic do_cycle(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    cmd = c; addr = a; din = d; tx_ready = rdy;
    #1;
    seen_dout = dout; seen_txd = tx_data; seen_txv = tx_valid; seen_mis = mis;
    check("dout", dout, m_load(c, a));
    check("tx_valid", {31'b0, tx_valid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) check("tx_data", {24'b0, tx_data}, {24'b0, mq[0]});
    check("misaligned", {31'b0, mis}, {31'b0, m_mis});
    m_step(c, a, d, rdy);
    @(negedge clk);
  endtask

  // Holds reset across one rising edge with a STATUS read applied.
  task automatic apply_reset();
    rst = 1'b0; cmd = LW; addr = BASE + 32'h4; din = 32'd0; tx_ready = 1'b1;
    #1;
    mq.delete(); m_mis = 1'b0; m_ovf = 1'b0; m_cyc = 32'd0;
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("rst_status", dout, 32'h1);
    check("rst_misaligned", {31'b0, mis}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra, rd;
    n_checks = 0; n_errors = 0;
    apply_reset();

    for (int w = 0; w < 64; w++) do_cycle(SW, 32'(w * 4), $urandom, 1'b0);

    // Byte loads with sign and zero extension
    do_cycle(SW, 32'h10, 32'h8899AABC, 1'b0);
    do_cycle(LB, 32'h10, 32'd0, 1'b0);  check("lb_10", seen_dout, 32'hFFFFFFBC);
    do_cycle(LB, 32'h11, 32'd0, 1'b0);  check("lb_11", seen_dout, 32'hFFFFFFAA);
    do_cycle(LB, 32'h13, 32'd0, 1'b0);  check("lb_13", seen_dout, 32'hFFFFFF88);
    do_cycle(LBU, 32'h13, 32'd0, 1'b0); check("lbu_13", seen_dout, 32'h00000088);

    // Halfword store into upper lane
    do_cycle(SW, 32'h20, 32'h0, 1'b0);
    do_cycle(SH, 32'h22, 32'h0000F00D, 1'b0);
    do_cycle(LW, 32'h20, 32'd0, 1'b0);  check("lw_20", seen_dout, 32'hF00D0000);
    do_cycle(LH, 32'h22, 32'd0, 1'b0);  check("lh_22", seen_dout, 32'hFFFFF00D);

    // Misaligned accesses and sticky flag clear
    do_cycle(LW, 32'h21, 32'd0, 1'b0);  check("lw_21_zero", seen_dout, 32'd0);
    do_cycle(SH, 32'h23, 32'h1234, 1'b0);
    check("mis_after_lw", {31'b0, seen_mis}, 32'd1);
    do_cycle(LW, 32'h20, 32'd0, 1'b0);  check("sh_23_nowrite", seen_dout, 32'hF00D0000);
    do_cycle(SW, BASE + 32'h4, 32'h8, 1'b0);
    do_cycle(NONE, 32'd0, 32'd0, 1'b0); check("mis_cleared", {31'b0, seen_mis}, 32'd0);

    // Overflow when pushing into a full FIFO, then full drain
    for (int i = 0; i < 9; i++) do_cycle(SW, BASE, 32'(8'h41 + i), 1'b0);
    do_cycle(LW, BASE + 32'h4, 32'd0, 1'b0); check("status_full_ovf", seen_dout, 32'h86);
    for (int i = 0; i < 8; i++) begin
      do_cycle(NONE, 32'd0, 32'd0, 1'b1);
      check("drain_valid", {31'b0, seen_txv}, 32'd1);
      check("drain_byte", {24'b0, seen_txd}, 32'(8'h41 + i));
    end
    do_cycle(NONE, 32'd0, 32'd0, 1'b1); check("drain_empty", {31'b0, seen_txv}, 32'd0);

    // Push while full with a same-cycle pop is accepted
    do_cycle(SW, BASE + 32'h4, 32'h4, 1'b0);
    for (int i = 0; i < 8; i++) do_cycle(SW, BASE, 32'(8'h60 + i), 1'b0);
    do_cycle(SW, BASE, 32'h50, 1'b1);
    do_cycle(LW, BASE + 32'h4, 32'd0, 1'b0); check("status_full_noovf", seen_dout, 32'h82);
    for (int i = 0; i < 8; i++) begin
      do_cycle(NONE, 32'd0, 32'd0, 1'b1);
      if (i == 7) check("last_byte_50", {24'b0, seen_txd}, 32'h50);
    end

`ifdef DMEM_CYCLE_CTR_EN
    do_cycle(SW, BASE + 32'h8, 32'hFFFFFFFE, 1'b0);
    do_cycle(LW, BASE + 32'h8, 32'd0, 1'b0); check("cyc_ffffffff", seen_dout, 32'hFFFFFFFF);
    do_cycle(LW, BASE + 32'h8, 32'd0, 1'b0); check("cyc_wrap", seen_dout, 32'h0);
`else
    do_cycle(SW, BASE + 32'h8, 32'hFFFFFFFE, 1'b0);
    do_cycle(LW, BASE + 32'h8, 32'd0, 1'b0); check("cyc_reserved", seen_dout, 32'h0);
`endif
    do_cycle(LW, BASE + 32'hC, 32'd0, 1'b0); check("reserved_c", seen_dout, 32'h0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      rd = $urandom;
      rc = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        6, 7: begin
          ra = BASE + 32'(4 * $urandom_range(0, 3));
          if ($urandom_range(0, 9) == 0) ra = BASE + 32'($urandom_range(0, 15));
          if ($urandom_range(0, 9) < 6) rc = SW;
          else if ($urandom_range(0, 1) == 1) rc = LW;
          if (ra == BASE + 32'h4 && $urandom_range(0, 3) != 0) rd = rd & 32'hFFFF_FFF3;
        end
        8: ra = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 + 32'($urandom_range(0, 255))
                                            : 32'(DEPTH_WORDS * 4) + 32'($urandom_range(0, 255));
        9: begin ra = 32'(4 * $urandom_range(0, 63)); rc = 4'($urandom_range(1, 8)); end
        default: ra = 32'($urandom_range(0, 255));
      endcase
      do_cycle(rc, ra, rd, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a drain
    for (int i = 0; i < 3; i++) do_cycle(SW, BASE, 32'(8'h70 + i), 1'b0);
    do_cycle(NONE, 32'd0, 32'd0, 1'b1);
    apply_reset();
    do_cycle(LW, BASE + 32'h4, 32'd0, 1'b0); check("post_rst_status", seen_dout, 32'h1);
    check("post_rst_valid", {31'b0, seen_txv}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
